// File: rtl/vga_pkg.sv
// Shared definitions for the VGA side of the game: display timing, board
// geometry, colour codes and the clear-engine state encoding.
package vga_pkg;

    // 640x480 @ 60 Hz timing, in pixel clocks / lines
    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = 800;
    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 29;
    localparam int V_TOTAL   = 521;

    // Playfield geometry: one RAM cell per board square, row-major
    localparam int BOARD_COLS    = 10;
    localparam int BOARD_ROWS    = 20;
    localparam int BOARD_CELLS   = BOARD_COLS * BOARD_ROWS;
    localparam int CELL_PX       = 24;
    localparam int BOARD_LEFT_PX = 344;

    // Colour codes stored per cell
    localparam logic [2:0] C_EMPTY   = 3'd0;
    localparam logic [2:0] C_RED     = 3'd1;
    localparam logic [2:0] C_GREEN   = 3'd2;
    localparam logic [2:0] C_BLUE    = 3'd3;
    localparam logic [2:0] C_YELLOW  = 3'd4;
    localparam logic [2:0] C_CYAN    = 3'd5;
    localparam logic [2:0] C_MAGENTA = 3'd6;
    localparam logic [2:0] C_WALL    = 3'd7;

    // Board clear engine states
    typedef enum logic [1:0] {
        CLR_IDLE = 2'd0,
        CLR_WAIT = 2'd1,
        CLR_RUN  = 2'd2
    } clr_state_e;

endpackage

// File: rtl/vram_arbiter.sv
// Single-port board RAM arbiter: display reads always win, then the clear
// engine (which only runs during vertical blanking), then game writes.
module vram_arbiter
    import vga_pkg::*;
#(
    parameter int DEPTH  = BOARD_CELLS,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 3
) (
    input  logic              i_pixclk,
    input  logic              i_rst_n,
    input  logic              i_rd_req,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid,
    input  logic              i_wr_valid,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_ready,
    input  logic              i_clear_req,
    input  logic              i_vblank,
    output logic              o_clear_busy,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    // Compare against the last valid cell so DEPTH == 2**ADDR_W still fits
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              rd_valid_q;
    logic              rd_oob_q;
    logic [DATA_W-1:0] rd_hold_q;
    logic [DATA_W-1:0] rd_data_now;
    logic              rd_in_range;
    logic              wr_in_range;
    logic              clr_write;
    logic              wr_ready;

    assign rd_in_range = (i_rd_addr <= LAST_ADDR);
    assign wr_in_range = (i_wr_addr <= LAST_ADDR);

    // Game writes only get through when the clear engine is idle and the display is quiet
    assign wr_ready = i_rst_n && (state_q == CLR_IDLE) && !i_rd_req;

    // Clear engine next state: wait for blanking, then sweep cells 0..DEPTH-1
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        cnt_d     = cnt_q;
        clr_write = 1'b0;
        if (i_rst_n) begin
            case (state_q)
                CLR_IDLE: if (i_clear_req) state_d = CLR_WAIT;
                CLR_WAIT: if (i_vblank) state_d = CLR_RUN;
                CLR_RUN: begin
                    if (!i_vblank) begin
                        state_d = CLR_WAIT;          // blanking over: pause, keep position
                    end else if (!i_rd_req) begin    // display read steals the port: stall
                        clr_write = 1'b1;
                        if (cnt_q == LAST_ADDR) begin
                            cnt_d   = '0;
                            state_d = CLR_IDLE;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = CLR_IDLE;
            endcase
        end
    end

    // RAM port mux: read > clear write > game write; out-of-range cells never touch the RAM
    always_comb begin
        o_mem_en    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (i_rst_n && i_rd_req) begin
            o_mem_en   = rd_in_range;
            o_mem_addr = i_rd_addr;
        end else if (clr_write) begin
            o_mem_en   = 1'b1;
            o_mem_we   = 1'b1;
            o_mem_addr = cnt_q;
        end else if (i_wr_valid && wr_ready && wr_in_range) begin
            o_mem_en    = 1'b1;
            o_mem_we    = 1'b1;
            o_mem_addr  = i_wr_addr;
            o_mem_wdata = i_wr_data;
        end
    end

    // State, clear counter and read-return tracking registers
    always_ff @(posedge i_pixclk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (!i_rst_n) begin
            state_q    <= CLR_IDLE;
            cnt_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_oob_q   <= 1'b0;
            rd_hold_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_valid_q <= i_rd_req;
            rd_oob_q   <= !rd_in_range;
            if (rd_valid_q) rd_hold_q <= rd_data_now;
        end
    end

    // Read data passes straight through from the RAM in the valid cycle, then holds
    assign rd_data_now  = rd_oob_q ? '0 : i_mem_rdata;
    assign o_rd_data    = rd_valid_q ? rd_data_now : rd_hold_q;
    assign o_rd_valid   = rd_valid_q;
    assign o_wr_ready   = wr_ready;
    assign o_clear_busy = (state_q != CLR_IDLE);

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port, synchronous-read board RAM (10x20 cells, 3-bit colour code per cell) between three users:
  - the VGA scan-out reader;
  - the game-logic cell writer;
  - an internal clear engine that wipes the board.
- Sits between the game state machine and the VGA pixel generator, in the pixel-clock domain.
- Guarantees the display a fixed-latency read every time it asks.

Parameters:
DEPTH, 200, number of board cells (10 columns x 20 rows)
ADDR_W, 8, cell address width
DATA_W, 3, colour code width per cell

Ports:
i_pixclk  input  1  pixel clock (25 MHz)
i_rst_n  input  1  synchronous reset, active-low
i_rd_req  input  1  display read request, one-cycle pulse
i_rd_addr  input  ADDR_W  display read cell address
o_rd_data  output  DATA_W  display read data
o_rd_valid  output  1  o_rd_data valid, exactly 1 cycle after i_rd_req
i_wr_valid  input  1  game write request
i_wr_addr  input  ADDR_W  game write address
i_wr_data  input  DATA_W  game write data
o_wr_ready  output  1  write accepted this cycle when high with i_wr_valid
i_clear_req  input  1  start board clear, one-cycle pulse
i_vblank  input  1  high during vertical blanking
o_clear_busy  output  1  clear pending or in progress
o_mem_en  output  1  RAM enable
o_mem_we  output  1  RAM write enable
o_mem_addr  output  ADDR_W  RAM address
o_mem_wdata  output  DATA_W  RAM write data
i_mem_rdata  input  DATA_W  RAM read data, valid 1 cycle after enabled read

Behaviour:
- Reset (i_rst_n low at a rising edge):
  - state IDLE, clear counter 0;
  - o_rd_valid, o_rd_data, o_clear_busy, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata all 0.
- Priority each cycle: display read > clear write > game write.
- Memory outputs are combinational from the granted request.
- Display read:
  - always granted;
  - o_mem_en=1, o_mem_we=0, o_mem_addr=i_rd_addr.
  - Next cycle: o_rd_valid=1 and o_rd_data=i_mem_rdata.
  - If i_rd_addr>=DEPTH: RAM is not enabled; next cycle o_rd_valid=1 with o_rd_data=0.
  - o_rd_data is held when o_rd_valid=0.
- Game write:
  - o_wr_ready = state==IDLE && !i_rd_req.
  - On valid&&ready: o_mem_en=1, o_mem_we=1, address/data from the i_wr_* ports.
  - If i_wr_addr>=DEPTH: accepted (ready handshake completes), but no RAM access.
- Clear state machine:
  - IDLE: i_clear_req -> WAIT, o_clear_busy=1 from the next cycle.
  - WAIT: i_vblank=1 -> RUN.
  - RUN, each cycle without i_rd_req:
    - write 0 to address cnt, then cnt++;
    - when cnt==DEPTH-1 is written -> IDLE, cnt=0, o_clear_busy=0 next cycle.
  - RUN, i_vblank=0: pause and return to WAIT; cnt is kept.
  - RUN, i_rd_req=1: cycle stalls, cnt is kept.
  - i_clear_req while busy: ignored.
  - i_clear_req in the same cycle as a game write in IDLE: the write is accepted; clear starts next cycle.
- Writes are blocked for the whole of WAIT/RUN: the game sees o_wr_ready=0.
- Reset mid-clear: abort; the board is left partially cleared; state IDLE.
- Latency:
  - read 1 cycle;
  - clear of an undisturbed blanking period: DEPTH cycles after entering RUN;
  - full clear spans frames if vblank ends first.

Decomposition:
- Shared package vga_pkg holds:
  - VGA timing constants (800/521 totals, porches, pulse widths);
  - board geometry (BOARD_COLS=10, BOARD_ROWS=20, CELL_PX=24, playfield left edge 344);
  - colour-code constants (C_EMPTY=0 ... C_WALL=7);
  - clear-FSM state encoding.
- No sub-module: the clear engine is ~40 lines inline. The RAM itself is an external instance.

Test Plan:
- Reset held 3 cycles then released -> all outputs 0, o_wr_ready=1, o_clear_busy=0.
- Write addr 17 data 5, then i_rd_req addr 17 -> o_wr_ready=1 on the write; o_rd_valid=1 with o_rd_data=5 exactly 1 cycle after the read request.
- Same-cycle i_rd_req addr 3 and i_wr_valid addr 4 data 2 -> RAM sees read of 3; o_wr_ready=0; write performed next cycle; later read of 4 returns 2.
- i_clear_req with i_vblank=0 for 10 cycles, then i_vblank=1 -> o_clear_busy=1; no RAM writes until vblank; then 200 consecutive zero writes to addresses 0..199; o_clear_busy falls 1 cycle after the address-199 write.
- During RUN: i_rd_req every 24th cycle and i_vblank dropped at cnt=120 -> reads still valid at 1-cycle latency; counter stalls on read cycles; resumes at 120 next vblank; no address skipped or repeated.
- i_rd_req addr 250 and i_wr_valid addr 230 -> read returns 0 with valid; write acknowledged; o_mem_en=0 for both.
